// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK flip-flops with shared synchronous clear and a mode select:
// per-bit JK, serial shift, binary up-count and parallel load. Define JK_REG_BANK_TC_EN to add tc.
module jk_reg_bank_cell (
    input  logic       cur,
    input  logic [1:0] mode,
    input  logic       j,
    input  logic       k,
    input  logic       shift_src,
    input  logic       carry,
    input  logic       ld,
    output logic       nxt
);
    always_comb begin
        nxt = cur;
        case (mode)
            2'b00: begin
                case ({j, k})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   nxt = ~cur;
                    default: nxt = cur;
                endcase
            end
            2'b01:   nxt = shift_src;
            2'b10:   nxt = cur ^ carry;
            default: nxt = ld;
        endcase
    end
endmodule

module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             sin,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
`ifdef JK_REG_BANK_TC_EN
    ,
    output logic             tc
`endif
);
    localparam logic [1:0] MODE_COUNT = 2'b10;

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] shift_src;
    logic [WIDTH-1:0] nxt;

    // carry[i] is the J=K toggle enable for bit i: all lower bits are ones
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            if (g == 0) begin : g_lsb
                assign carry[g]     = 1'b1;
                assign shift_src[g] = sin;
            end else begin : g_upper
                assign carry[g]     = carry[g-1] & q[g-1];
                assign shift_src[g] = q[g-1];
            end
            jk_reg_bank_cell u_cell (
                .cur       (q[g]),
                .mode      (mode),
                .j         (j[g]),
                .k         (k[g]),
                .shift_src (shift_src[g]),
                .carry     (carry[g]),
                .ld        (d[g]),
                .nxt       (nxt[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear)
            q <= RESET_VAL;
        else if (en)
            q <= nxt;
    end

    assign qbar = ~q;

`ifdef JK_REG_BANK_TC_EN
    // tc flags the count wrap only; any other path to zero leaves it low
    always_ff @(posedge clk) begin
        if (clear)
            tc <= 1'b0;
        else
            tc <= en && (mode == MODE_COUNT) && (&q);
    end
`endif
endmodule
